// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions: transfer/size/response codes, slave FSM states
// and the address-check and lane-merge helpers used by master and slave.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } ahb_state_e;

    // Out-of-range word index or a half/word access not aligned to its size.
    function automatic logic addr_error(input logic [31:0] haddr,
                                        input logic [2:0]  hsize,
                                        input logic [31:0] depth);
        logic bad;
        bad = ({2'b00, haddr[31:2]} >= depth);
        if (hsize == HSIZE_HALF) begin
            bad = bad | haddr[0];
        end else if (hsize >= HSIZE_WORD) begin
            bad = bad | (haddr[1:0] != 2'b00);
        end else begin
            bad = bad | 1'b0;
        end
        return bad;
    endfunction

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  lane_en);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = lane_en[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/ahb_byte_lane_mask.sv
// Little-endian byte-lane enable for a 32-bit AHB data bus from HSIZE and the
// low address bits; sizes above word collapse to all four lanes.
module ahb_byte_lane_mask
    import ahb_pkg::*;
(
    input  logic [2:0] hsize,
    input  logic [1:0] addr,
    output logic [3:0] lane_en
);

    // Lane decode
    always_comb begin
        lane_en = 4'b0000;
        case (hsize)
            HSIZE_BYTE: lane_en = 4'b0001 << addr;
            HSIZE_HALF: begin
                if (addr[1]) begin
                    lane_en = 4'b1100;
                end else begin
                    lane_en = 4'b0011;
                end
            end
            default:    lane_en = 4'b1111;
        endcase
    end

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite single-port word SRAM slave with byte-lane writes, programmable
// wait states, two-cycle ERROR responses and read-after-write forwarding.
module ahb_slave_mem
    import ahb_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0,
    parameter int AW          = $clog2(DEPTH)
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);

    localparam logic       ZERO_WAIT = (WAIT_STATES == 0);
    localparam logic [3:0] WS_LOAD   = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    ahb_state_e    state_r;
    ahb_state_e    state_nxt_s;
    logic [3:0]    wait_cnt_r;
    logic          pend_r;
    logic          write_r;
    logic [AW-1:0] addr_r;
    logic [1:0]    offs_r;
    logic [2:0]    size_r;
    logic [3:0]    lane_en_s;
    logic          accept_s;
    logic          good_s;
    logic          addr_bad_s;
    logic [AW-1:0] haddr_idx_s;
    logic          commit_s;
    logic          hreadyout_r;
    logic          hresp_r;
    logic          hreadyout_nxt_s;
    logic          hresp_nxt_s;
    logic [31:0]   hrdata_r;
    logic [31:0]   rdata_nxt_s;
    logic [31:0]   mem_r [DEPTH];
    logic          unused_s;

    // HBURST and HTRANS[0] carry no information for a slave that follows HADDR
    assign unused_s    = ^{HBURST, HTRANS[0]};

    assign accept_s    = HSEL & HREADY & HTRANS[1] & hreadyout_r;
    assign addr_bad_s  = addr_error(HADDR, HSIZE, 32'(DEPTH));
    assign good_s      = accept_s & ~addr_bad_s;
    assign haddr_idx_s = HADDR[AW+1:2];
    assign commit_s    = pend_r & write_r & hreadyout_r;

    ahb_byte_lane_mask u_lane_mask (
        .hsize   (size_r),
        .addr    (offs_r),
        .lane_en (lane_en_s)
    );

    // FSM state register and registered bus outputs
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_r     <= ST_IDLE;
            hreadyout_r <= 1'b1;
            hresp_r     <= HRESP_OKAY;
            hrdata_r    <= 32'h0000_0000;
        end else begin
            state_r     <= state_nxt_s;
            hreadyout_r <= hreadyout_nxt_s;
            hresp_r     <= hresp_nxt_s;
            hrdata_r    <= rdata_nxt_s;
        end
    end

    // FSM next-state; IDLE and ERR2 both present HREADYOUT=1 and accept transfers
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE, ST_ERR2: begin
                if (accept_s && addr_bad_s) begin
                    state_nxt_s = ST_ERR1;
                end else if (good_s && !ZERO_WAIT) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_r == 4'd0) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_ERR1: state_nxt_s = ST_ERR2;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM outputs, decoded from the next state so they can be registered
    always_comb begin
        hreadyout_nxt_s = 1'b1;
        hresp_nxt_s     = HRESP_OKAY;
        case (state_nxt_s)
            ST_WAIT: hreadyout_nxt_s = 1'b0;
            ST_ERR1: begin
                hreadyout_nxt_s = 1'b0;
                hresp_nxt_s     = HRESP_ERROR;
            end
            ST_ERR2: hresp_nxt_s = HRESP_ERROR;
            default: hreadyout_nxt_s = 1'b1;
        endcase
    end

    // Read data for the upcoming final data-phase cycle; merges a same-word write in flight
    always_comb begin
        rdata_nxt_s = hrdata_r;
        if (good_s && !HWRITE && ZERO_WAIT) begin
            if (commit_s && (addr_r == haddr_idx_s)) begin
                rdata_nxt_s = merge_lanes(mem_r[haddr_idx_s], HWDATA, lane_en_s);
            end else begin
                rdata_nxt_s = mem_r[haddr_idx_s];
            end
        end else if ((state_r == ST_WAIT) && (wait_cnt_r == 4'd0) && pend_r && !write_r) begin
            rdata_nxt_s = mem_r[addr_r];
        end else begin
            rdata_nxt_s = hrdata_r;
        end
    end

    // Wait-state down-counter
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wait_cnt_r <= 4'd0;
        end else if (good_s) begin
            wait_cnt_r <= WS_LOAD;
        end else if ((state_r == ST_WAIT) && (wait_cnt_r != 4'd0)) begin
            wait_cnt_r <= wait_cnt_r - 4'd1;
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // Pending data-phase record; retires on the final HREADYOUT=1 cycle
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pend_r  <= 1'b0;
            write_r <= 1'b0;
            addr_r  <= '0;
            offs_r  <= 2'b00;
            size_r  <= 3'd0;
        end else if (accept_s) begin
            pend_r  <= ~addr_bad_s;
            write_r <= HWRITE;
            addr_r  <= haddr_idx_s;
            offs_r  <= HADDR[1:0];
            size_r  <= HSIZE;
        end else if (pend_r && hreadyout_r) begin
            pend_r  <= 1'b0;
        end
    end

    // Storage array; contents deliberately survive reset
    always_ff @(posedge HCLK) begin
        if (commit_s) begin
            mem_r[addr_r] <= merge_lanes(mem_r[addr_r], HWDATA, lane_en_s);
        end
    end

    assign HREADYOUT = hreadyout_r;
    assign HRESP     = hresp_r;
    assign HRDATA    = hrdata_r;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Randomised self-checking bench for ahb_slave_mem: a zero-wait and a two-wait
// instance driven by a pipelined AHB master task against a word-array model.
module tb_ahb_slave_mem;
    import ahb_pkg::*;

    localparam int DEPTH = 256;
    localparam int WS0   = 0;
    localparam int WS1   = 2;

    typedef struct packed {
        logic        act;
        logic        sel;
        logic [1:0]  trans;
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
    } txn_t;

    logic        clk;
    logic        rst_n;
    logic        hsel      [2];
    logic [31:0] haddr     [2];
    logic [1:0]  htrans    [2];
    logic        hwrite    [2];
    logic [2:0]  hsize     [2];
    logic [2:0]  hburst    [2];
    logic [31:0] hwdata    [2];
    logic        hreadyout [2];
    logic        hresp     [2];
    logic [31:0] hrdata    [2];

    int          n_checks;
    int          n_errors;
    txn_t        q [$];
    logic [31:0] rd_log [$];
    logic [31:0] model_mem [2][DEPTH];

    ahb_slave_mem #(.DEPTH(DEPTH), .WAIT_STATES(WS0)) u_dut0 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel[0]), .HADDR(haddr[0]), .HTRANS(htrans[0]),
        .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HBURST(hburst[0]), .HWDATA(hwdata[0]),
        .HREADY(hreadyout[0]), .HREADYOUT(hreadyout[0]), .HRESP(hresp[0]), .HRDATA(hrdata[0])
    );

    ahb_slave_mem #(.DEPTH(DEPTH), .WAIT_STATES(WS1)) u_dut1 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel[1]), .HADDR(haddr[1]), .HTRANS(htrans[1]),
        .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HBURST(hburst[1]), .HWDATA(hwdata[1]),
        .HREADY(hreadyout[1]), .HREADYOUT(hreadyout[1]), .HRESP(hresp[1]), .HRDATA(hrdata[1])
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int ws_of(input int d);
        return (d == 0) ? WS0 : WS1;
    endfunction

    function automatic int size_bytes(input logic [2:0] size);
        return (size == 3'd0) ? 1 : ((size == 3'd1) ? 2 : 4);
    endfunction

    function automatic bit model_bad(input logic [31:0] addr, input logic [2:0] size);
        return ((addr / 4) >= DEPTH) || ((addr % size_bytes(size)) != 0);
    endfunction

    function automatic logic [31:0] model_merge(input logic [31:0] old_word, input logic [31:0] wd,
                                                input logic [31:0] addr, input logic [2:0] size);
        int nb;
        int first;
        logic [31:0] r;
        nb    = size_bytes(size);
        first = (int'(addr % 4) / nb) * nb;
        r     = old_word;
        for (int b = 0; b < 4; b++) begin
            if ((b >= first) && (b < first + nb)) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

    task automatic push(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] wdata, input logic [1:0] trans);
        txn_t t;
        t.act = 1'b1; t.sel = 1'b1; t.trans = trans; t.wr = wr;
        t.addr = addr; t.size = size; t.wdata = wdata;
        q.push_back(t);
    endtask

    task automatic push_gap(input int kind);
        txn_t t;
        t.act   = 1'b0;
        t.sel   = (kind == 2) ? 1'b0 : 1'b1;
        t.trans = (kind == 0) ? HTRANS_IDLE : ((kind == 1) ? HTRANS_BUSY : HTRANS_NONSEQ);
        t.wr    = 1'($urandom_range(0, 1));
        t.addr  = 32'($urandom_range(0, DEPTH * 4 - 1));
        t.size  = 3'd2;
        t.wdata = $urandom();
        q.push_back(t);
    endtask

    task automatic present(input int d, input int i);
        if (i >= q.size()) begin
            hsel[d]   = 1'b0;
            htrans[d] = HTRANS_IDLE;
            hwrite[d] = 1'b0;
        end else begin
            hsel[d]   = q[i].sel;
            htrans[d] = q[i].trans;
            hwrite[d] = q[i].wr;
            haddr[d]  = q[i].addr;
            hsize[d]  = q[i].size;
            hburst[d] = 3'($urandom_range(0, 7));
        end
    endtask

    // Pipelined master: samples at negedge, drives just after posedge.
    task automatic run_seq(input int d, output int data_cycles);
        int   cur;
        int   nxt;
        int   waits;
        int   guard;
        int   idx;
        logic acc;
        logic bad;
        txn_t t;
        data_cycles = 0; cur = -1; nxt = 0; waits = 0; guard = 0;
        rd_log.delete();
        present(d, nxt);
        while ((cur >= 0) || (nxt < q.size())) begin
            @(negedge clk);
            acc = hreadyout[d];
            if (cur >= 0) begin
                t   = q[cur];
                bad = model_bad(t.addr, t.size);
                idx = int'(t.addr >> 2);
                data_cycles++;
                if (!hreadyout[d]) begin
                    check_eq("resp_stall", 32'(hresp[d]), 32'(bad));
                    waits++;
                end else begin
                    check_eq("resp_final", 32'(hresp[d]), 32'(bad));
                    check_eq("ready_low_cycles", waits, bad ? 1 : ws_of(d));
                    if (!bad && !t.wr) begin
                        check_eq("rdata", hrdata[d], model_mem[d][idx]);
                        rd_log.push_back(hrdata[d]);
                    end
                    if (!bad && t.wr) model_mem[d][idx] = model_merge(model_mem[d][idx], t.wdata, t.addr, t.size);
                    waits = 0;
                end
            end else begin
                check_eq("idle_ready", 32'(hreadyout[d]), 32'd1);
                check_eq("idle_resp", 32'(hresp[d]), 32'd0);
            end
            guard++;
            if (guard > 4000) begin
                check_eq("seq_timeout", guard, 0);
                break;
            end
            @(posedge clk); #1;
            if (acc) begin
                if ((nxt < q.size()) && q[nxt].act) cur = nxt;
                else cur = -1;
                if (nxt < q.size()) nxt++;
                hwdata[d] = (cur >= 0) ? q[cur].wdata : $urandom();
                present(d, nxt);
            end
        end
        present(d, q.size());
        q.delete();
    endtask

    initial begin
        int          dc;
        int          nb;
        logic [31:0] a;
        n_checks = 0; n_errors = 0;
        clk = 1'b0; rst_n = 1'b1;
        for (int d = 0; d < 2; d++) begin
            hsel[d] = 1'b0; htrans[d] = HTRANS_IDLE; hwrite[d] = 1'b0; haddr[d] = 32'd0;
            hsize[d] = 3'd0; hburst[d] = 3'd0; hwdata[d] = 32'd0;
        end
        #3 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check_eq("reset_ready", 32'(hreadyout[d]), 32'd1);
            check_eq("reset_resp", 32'(hresp[d]), 32'd0);
            check_eq("reset_rdata", hrdata[d], 32'd0);
        end
        @(negedge clk); rst_n = 1'b1;

        // Known contents everywhere so every later read has a defined expectation
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < DEPTH; i++) push(1'b1, 32'(i * 4), 3'd2, $urandom(), (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ);
            @(posedge clk); #1;
            run_seq(d, dc);
        end

        // Zero-wait word write/read, byte merge, back-to-back forwarding
        push(1'b1, 32'h0, 3'd2, 32'h0000_000A, HTRANS_NONSEQ);
        push(1'b0, 32'h0, 3'd2, 32'h0, HTRANS_NONSEQ);
        push(1'b1, 32'h4, 3'd2, 32'h1122_3344, HTRANS_NONSEQ);
        push(1'b1, 32'h5, 3'd0, 32'h0000_FF00, HTRANS_NONSEQ);
        push(1'b0, 32'h4, 3'd2, 32'h0, HTRANS_NONSEQ);
        push(1'b1, 32'h8, 3'd2, 32'h0000_000F, HTRANS_NONSEQ);
        push(1'b0, 32'h8, 3'd2, 32'h0, HTRANS_NONSEQ);
        @(posedge clk); #1;
        run_seq(0, dc);
        check_eq("plan_read_count", rd_log.size(), 3);
        if (rd_log.size() == 3) begin
            check_eq("plan_word_read", rd_log[0], 32'h0000_000A);
            check_eq("plan_byte_merge", rd_log[1], 32'h1122_FF44);
            check_eq("plan_forward", rd_log[2], 32'h0000_000F);
        end
        check_eq("plan_zero_wait_cycles", dc, 7);

        // Two wait states: single read and a 4-beat INCR with HSIZE=3
        push(1'b0, 32'h0, 3'd2, 32'h0, HTRANS_NONSEQ);
        @(posedge clk); #1;
        run_seq(1, dc);
        check_eq("ws2_single_cycles", dc, 3);
        for (int i = 0; i < 4; i++) push(1'b0, 32'(i * 4), 3'd3, 32'h0, (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ);
        @(posedge clk); #1;
        run_seq(1, dc);
        check_eq("ws2_incr4_cycles", dc, 12);

        // ERROR cases: out of range, misaligned half write, burst crossing the top
        for (int d = 0; d < 2; d++) begin
            push(1'b0, 32'h400, 3'd2, 32'h0, HTRANS_NONSEQ);
            push(1'b1, 32'h1, 3'd1, 32'hA5A5_5A5A, HTRANS_NONSEQ);
            push(1'b0, 32'h0, 3'd2, 32'h0, HTRANS_NONSEQ);
            push(1'b0, 32'h3F8, 3'd2, 32'h0, HTRANS_NONSEQ);
            push(1'b0, 32'h3FC, 3'd2, 32'h0, HTRANS_SEQ);
            push(1'b0, 32'h400, 3'd2, 32'h0, HTRANS_SEQ);
            push_gap(0);
            @(posedge clk); #1;
            run_seq(d, dc);
        end

        // Reset during the wait cycle of a write
        @(posedge clk); #1;
        hsel[1] = 1'b1; htrans[1] = HTRANS_NONSEQ; hwrite[1] = 1'b1; haddr[1] = 32'h10; hsize[1] = 3'd2;
        @(posedge clk); #1;
        hwdata[1] = 32'hDEAD_BEEF;
        check_eq("rst_mid_stalled", 32'(hreadyout[1]), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_mid_ready", 32'(hreadyout[1]), 32'd1);
        check_eq("rst_mid_resp", 32'(hresp[1]), 32'd0);
        check_eq("rst_mid_rdata", hrdata[1], 32'd0);
        present(1, 0);
        @(negedge clk); rst_n = 1'b1;
        push(1'b0, 32'h10, 3'd2, 32'h0, HTRANS_NONSEQ);
        @(posedge clk); #1;
        run_seq(1, dc);

        // Random traffic
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 200; i++) begin
                if ($urandom_range(0, 9) < 2) begin
                    push_gap(int'($urandom_range(0, 2)));
                end else begin
                    logic [2:0] sz;
                    sz = 3'($urandom_range(0, 7));
                    nb = size_bytes(sz);
                    if ($urandom_range(0, 9) == 0) begin
                        a = 32'($urandom_range(0, 32'h47F));
                    end else begin
                        a = 32'($urandom_range(0, DEPTH * 4 - 1));
                        a = a - (a % nb);
                    end
                    push(1'($urandom_range(0, 1)), a, sz, $urandom(),
                         ($urandom_range(0, 1) == 0) ? HTRANS_NONSEQ : HTRANS_SEQ);
                end
            end
            @(posedge clk); #1;
            run_seq(d, dc);
        end

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ahb_slave_mem.md
Name: ahb_slave_mem

Overview:
- Single-port AHB-Lite slave memory that sits directly downstream of the AHB master/ALU/register-file block.
- Consumes its HADDR/HTRANS/HWRITE/HSIZE/HBURST/HWDATA outputs and returns HRDATA/HREADY/HRESP.
- Word-organised SRAM model with byte-lane writes, programmable wait states and ERROR responses.
- Serves as the bus target for system integration and for bench closure of the master.

Parameters:
- DEPTH, 256, number of 32-bit words; valid byte addresses are 0 .. 4*DEPTH-1.
- WAIT_STATES, 0, HREADYOUT-low cycles inserted in each data phase (0..15).
- AW, $clog2(DEPTH), word-index width.

Ports:
- HCLK  in  1  bus clock; all state changes on the rising edge.
- HRESETn  in  1  asynchronous active-low reset.
- HSEL  in  1  slave select.
- HADDR  in  32  byte address.
- HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  0 = byte, 1 = half, 2 or more = word (the bus is 32-bit; values 3..7 are treated as word).
- HBURST  in  3  ignored for addressing; the slave follows HADDR each beat.
- HWDATA  in  32  write data, valid in the data phase.
- HREADY  in  1  bus-level ready (this slave's HREADYOUT in a single-slave system).
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.
- HRDATA  out  32  read data.

Behaviour:
- Reset (async, HRESETn=0): HREADYOUT=1, HRESP=0, HRDATA=0, FSM=IDLE, pending transfer cleared. Memory contents are not reset.
- Address phase accepted when HSEL & HREADY & HTRANS[1]. On acceptance, register addr, write, size, and check result.
- IDLE/BUSY transfers, or HSEL=0: no access, next cycle OKAY with zero wait.
- Error check at acceptance:
  - word index HADDR[31:2] >= DEPTH → ERROR;
  - HSIZE=1 with HADDR[0]=1 → ERROR;
  - HSIZE>=2 with HADDR[1:0]!=0 → ERROR.
- FSM states: IDLE, WAIT, ERR1, ERR2.
  - IDLE: on an accepted good transfer, go to WAIT if WAIT_STATES>0, else stay in the data phase with HREADYOUT=1. On an accepted bad transfer, go to ERR1.
  - WAIT: HREADYOUT=0, HRESP=0; a down-counter loads WAIT_STATES-1 and decrements. At 0 the next cycle is the final data-phase cycle with HREADYOUT=1.
  - ERR1: HREADYOUT=0, HRESP=1. ERR2 follows: HREADYOUT=1, HRESP=1, then IDLE. A transfer presented during ERR2 is accepted normally.
- Write commit: in the final data-phase cycle (HREADYOUT=1), HWDATA byte lanes are merged into mem[addr_q]. Lane selection is little-endian: byte → lane HADDR[1:0]; half → lanes {HADDR[1],0} and {HADDR[1],1}; word → all four lanes. No write on ERROR.
- Read: HRDATA is valid when HREADYOUT=1 in the data phase; it holds the full 32-bit word and the master extracts the lanes. HRDATA holds its last value otherwise.
- Zero-wait latency: data is returned in the cycle immediately after the address phase.
- Read-after-write forwarding: if a read address phase coincides with the final data phase of a write to the same word, the returned word is the memory word merged with the written lanes. No stale data is allowed.
- Back-to-back pipelined transfers, NONSEQ/SEQ: zero bubbles when WAIT_STATES=0.
- While HREADYOUT=0, new address-phase inputs are ignored; the master holds them.
- Address wrap: none; bursts crossing the top of memory get ERROR on the offending beat only.
- Reset asserted mid-transfer: the pending write is discarded and the memory word is unchanged.

Decomposition:
- Shared package ahb_pkg: HTRANS codes (IDLE/BUSY/NONSEQ/SEQ), HSIZE codes, HRESP codes, FSM state typedef. The package is reused by the master.
- One sub-module, ahb_byte_lane_mask: combinational HSIZE + HADDR[1:0] → 4-bit lane enable. It is reused by the forwarding merge and the write path.

Test Plan:
- WAIT_STATES=0: write word 0x0000000A to addr 0x0, then read 0x0 → HRDATA=0x0000000A one cycle after the read address phase; HRESP=0 throughout.
- Byte write 0xFF to addr 0x5 (HSIZE=0) over word 0x11223344 at 0x4, then read 0x4 → 0x1122FF44.
- Back-to-back write 0x0F to 0x8 immediately followed by read 0x8 → HRDATA=0x0000000F via forwarding, no stall.
- WAIT_STATES=2: single read → HREADYOUT low for exactly 2 cycles, then high with correct data. A 4-beat INCR read from 0x0 (HSIZE=3) takes 12 data cycles, with word reads at 0x0/0x4/0x8/0xC.
- Read addr 0x400 with DEPTH=256 → HREADYOUT=0/HRESP=1, then HREADYOUT=1/HRESP=1, then OKAY idle. Half-word write at 0x1 → same ERROR pair and memory unchanged.
- Assert HRESETn=0 during the WAIT cycle of a write of 0xDEADBEEF to 0x10 → outputs HREADYOUT=1/HRESP=0/HRDATA=0 immediately; a later read of 0x10 returns the prior contents.
